// File: rtl/toggle_event_receiver_pkg.sv
// Shared FSM encodings and default sizing for the toggle-event receiver.
// No logic; latency and backpressure are defined by the modules that import it.
package toggle_event_receiver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_LOST    = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/toggle_sync.sv
// SYNC_STAGES-deep flop chain bringing a toggle line into clk; level is the last stage.
// Latency SYNC_STAGES cycles from capture; no backpressure, the line is sampled every cycle.
module toggle_sync
  import toggle_event_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  output logic level
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= toggle_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign level = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Turns each flip of a toggle line into a pulse, a wrapping count and a valid/ack event.
// Pulse/count/FSM update SYNC_STAGES edges after capture; an unacked event plus a new one flags overrun.
module toggle_event_receiver
  import toggle_event_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  output logic             level,
  output logic             pulse,
  output logic             evt_valid,
  input  logic             evt_ack,
  output logic [CNT_W-1:0] evt_count,
  output logic             overrun,
  input  logic             clr_overrun
);

  logic             w_level;
  logic             w_edge;
  logic             w_set_ovr;
  logic             r_prev;
  logic             r_pulse;
  logic             r_overrun;
  logic [CNT_W-1:0] r_count;
  state_t           r_state;
  state_t           w_next;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .toggle_in(toggle_in),
    .level    (w_level)
  );

  assign w_edge = w_level ^ r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev    <= 1'b0;
      r_pulse   <= 1'b0;
      r_count   <= '0;
      r_overrun <= 1'b0;
      r_state   <= ST_IDLE;
    end else begin
      r_prev  <= w_level;
      r_pulse <= w_edge;
      r_state <= w_next;
      if (w_edge) begin
        r_count <= r_count + CNT_W'(1);
      end
      // A new drop in the same cycle as a clear must stay visible.
      if (w_set_ovr) begin
        r_overrun <= 1'b1;
      end else if (clr_overrun) begin
        r_overrun <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ovr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_edge) w_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (w_edge) begin
          if (!evt_ack) begin
            w_next    = ST_LOST;
            w_set_ovr = 1'b1;
          end
        end else if (evt_ack) begin
          w_next = ST_IDLE;
        end
      end
      ST_LOST: begin
        if (w_edge) begin
          w_set_ovr = 1'b1;
          w_next    = evt_ack ? ST_PENDING : ST_LOST;
        end else if (evt_ack) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign level     = w_level;
  assign pulse     = r_pulse;
  assign evt_valid = (r_state == ST_PENDING) || (r_state == ST_LOST);
  assign evt_count = r_count;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver: per-cycle vector table, pulse scoreboard and hand-written corner sequences.
`timescale 1ns/1ps
module tb_toggle_event_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       toggle_in;
  logic       level;
  logic       pulse;
  logic       evt_valid;
  logic       evt_ack;
  logic [7:0] evt_count;
  logic       overrun;
  logic       clr_overrun;

  toggle_event_receiver #(
    .SYNC_STAGES(2),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .toggle_in  (toggle_in),
    .level      (level),
    .pulse      (pulse),
    .evt_valid  (evt_valid),
    .evt_ack    (evt_ack),
    .evt_count  (evt_count),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       tgl;
    logic       ack;
    logic       clr;
    logic       lvl;
    logic       pls;
    logic       vld;
    logic [7:0] cnt;
    logic       ovr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] m_cnt;
  logic       m_line;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string nm, input logic l, input logic p, input logic v,
                         input logic [7:0] c, input logic o);
    chk({nm, ".level"},     32'(level),     32'(l));
    chk({nm, ".pulse"},     32'(pulse),     32'(p));
    chk({nm, ".evt_valid"}, 32'(evt_valid), 32'(v));
    chk({nm, ".evt_count"}, 32'(evt_count), 32'(c));
    chk({nm, ".overrun"},   32'(overrun),   32'(o));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every real transition of the line is expected to produce exactly one pulse.
  task automatic drive_tgl(input logic v);
    if (v !== m_line) begin
      m_cnt = m_cnt + 8'd1;
      sb.push_back(m_cnt);
      m_line = v;
    end
    toggle_in = v;
  endtask

  task automatic add(input logic t, input logic a, input logic c, input logic l,
                     input logic p, input logic v, input logic [7:0] n, input logic o);
    vec_t x;
    x = {t, a, c, l, p, v, n, o};
    vecs.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (pulse === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_pulse", 32'(pulse), 32'd0);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("sb_count", 32'(evt_count), 32'(e));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //  tgl ack clr | lvl pls vld cnt ovr
    add(1, 1, 0,  0, 0, 0, 0,  0); add(1, 1, 0,  1, 0, 0, 0,  0);
    add(1, 1, 0,  1, 1, 1, 1,  0); add(1, 1, 0,  1, 0, 0, 1,  0);
    add(0, 1, 0,  1, 0, 0, 1,  0); add(0, 1, 0,  0, 0, 0, 1,  0);
    add(0, 1, 0,  0, 1, 1, 2,  0); add(0, 1, 0,  0, 0, 0, 2,  0);
    add(1, 0, 0,  0, 0, 0, 2,  0); add(1, 0, 0,  1, 0, 0, 2,  0);
    add(1, 0, 0,  1, 1, 1, 3,  0); add(1, 0, 0,  1, 0, 1, 3,  0);
    add(0, 0, 0,  1, 0, 1, 3,  0); add(0, 0, 0,  0, 0, 1, 3,  0);
    add(0, 0, 0,  0, 1, 1, 4,  1); add(0, 0, 0,  0, 0, 1, 4,  1);
    add(1, 0, 0,  0, 0, 1, 4,  1); add(1, 0, 0,  1, 0, 1, 4,  1);
    add(1, 0, 0,  1, 1, 1, 5,  1); add(1, 1, 0,  1, 0, 0, 5,  1);
    add(1, 0, 1,  1, 0, 0, 5,  0);
    add(0, 0, 0,  1, 0, 0, 5,  0); add(0, 0, 0,  0, 0, 0, 5,  0);
    add(0, 0, 0,  0, 1, 1, 6,  0); add(0, 0, 0,  0, 0, 1, 6,  0);
    add(1, 0, 0,  0, 0, 1, 6,  0); add(1, 0, 0,  1, 0, 1, 6,  0);
    add(1, 1, 0,  1, 1, 1, 7,  0); add(1, 0, 0,  1, 0, 1, 7,  0);
    add(1, 1, 0,  1, 0, 0, 7,  0);
    add(0, 0, 0,  1, 0, 0, 7,  0); add(0, 0, 0,  0, 0, 0, 7,  0);
    add(0, 0, 0,  0, 1, 1, 8,  0); add(0, 0, 0,  0, 0, 1, 8,  0);
    add(1, 0, 0,  0, 0, 1, 8,  0); add(1, 0, 0,  1, 0, 1, 8,  0);
    add(1, 0, 1,  1, 1, 1, 9,  1); add(1, 0, 1,  1, 0, 1, 9,  0);
    add(1, 0, 0,  1, 0, 1, 9,  0);
    add(0, 0, 0,  1, 0, 1, 9,  0); add(0, 0, 0,  0, 0, 1, 9,  0);
    add(0, 1, 0,  0, 1, 1, 10, 1); add(0, 1, 0,  0, 0, 0, 10, 1);
    add(0, 0, 1,  0, 0, 0, 10, 0);

    rst = 1'b0; toggle_in = 1'b1; evt_ack = 1'b0; clr_overrun = 1'b0;
    m_line = 1'b0; m_cnt = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("reset%0d", i), 0, 0, 0, 8'd0, 0);
    end
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive_tgl(vecs[i].tgl);
      evt_ack     = vecs[i].ack;
      clr_overrun = vecs[i].clr;
      tick();
      chk_all($sformatf("v%0d", i), vecs[i].lvl, vecs[i].pls, vecs[i].vld,
              vecs[i].cnt, vecs[i].ovr);
    end
    evt_ack = 1'b0; clr_overrun = 1'b0;

    // Reset while a transition is still inside the synchroniser and an event is pending.
    drive_tgl(1'b1);
    repeat (4) tick();
    chk("inflight.pre_valid", 32'(evt_valid), 32'd1);
    toggle_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk_all("inflight_rst", 0, 0, 0, 8'd0, 0);
    repeat (2) tick();
    rst = 1'b1; m_line = 1'b0; m_cnt = 8'd0;
    repeat (5) tick();
    chk_all("inflight_after", 0, 0, 0, 8'd0, 0);
    drive_tgl(1'b1);
    repeat (4) tick();
    chk("inflight.later_cnt",   32'(evt_count), 32'd1);
    chk("inflight.later_valid", 32'(evt_valid), 32'd1);

    // Counter wrap over 257 events.
    rst = 1'b0; toggle_in = 1'b0;
    repeat (2) tick();
    rst = 1'b1; m_line = 1'b0; m_cnt = 8'd0; evt_ack = 1'b1;
    for (int n = 1; n <= 257; n++) begin
      drive_tgl(~m_line);
      repeat (4) tick();
      if (n == 255) chk("wrap.255", 32'(evt_count), 32'd255);
      if (n == 256) chk("wrap.256", 32'(evt_count), 32'd0);
      if (n == 257) chk("wrap.257", 32'(evt_count), 32'd1);
    end
    chk("wrap.overrun", 32'(overrun), 32'd0);
    repeat (4) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
- Receive end of the toggle-signalling link. A transmitter built on the team's T flip-flop flips one line once per event; this block turns each flip back into a discrete event.
- Synchronises the incoming toggle line into clk, detects every transition and emits a one-cycle pulse for each one.
- Keeps a wrapping event count and presents each event to a consumer over a valid/ack handshake, with sticky overrun detection.
- Sits on the consumer side of any clock/domain boundary the toggle line crosses.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on toggle_in; legal range 1..3.
- CNT_W, 8, width of the event counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on rising clk.
- toggle_in  in  1  toggle line from the transmitter's T flip-flop q output; may be asynchronous to clk.
- level  out  1  synchronised, delayed copy of toggle_in; this is the last synchroniser stage.
- pulse  out  1  one-cycle strobe per detected transition.
- evt_valid  out  1  at least one unacknowledged event is pending.
- evt_ack  in  1  consumer accepts the pending event; ignored while evt_valid=0.
- evt_count  out  CNT_W  total detected transitions since reset, modulo 2^CNT_W.
- overrun  out  1  sticky flag: an event arrived while a previous one was still pending.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (rst=0 at a rising edge):
  - Synchroniser chain, prev-level register, pulse, evt_count, overrun and FSM all clear.
  - Resulting outputs: level=0, pulse=0, evt_valid=0, evt_count=0, overrun=0.
  - The line's idle level after reset is defined as 0. The transmitter must also reset to q=0.
  - Reset asserted mid-operation discards any in-flight transition and any pending event.
- Edge detection:
  - edge = level XOR prev; prev <= level on every edge.
  - Rising and falling transitions both count as one event each.
- Latency:
  - Suppose toggle_in changes and is first captured at edge k.
  - level changes after edge k+SYNC_STAGES-1.
  - pulse is registered and is high for exactly one cycle after edge k+SYNC_STAGES.
  - evt_count and the FSM update on that same edge k+SYNC_STAGES.
- Toggle rate: toggle_in must hold each level for at least SYNC_STAGES+1 clk cycles. Faster toggling may lose events; the block does not detect that loss.
- Counter: evt_count increments by 1 on each edge and wraps from 2^CNT_W-1 to 0. Wrapping is not an overrun.
- FSM, 3 states:
  - IDLE: evt_valid=0. edge -> PENDING.
  - PENDING: evt_valid=1.
    - ack & !edge -> IDLE.
    - ack & edge -> stay PENDING (new event replaces the acked one).
    - !ack & edge -> LOST, and set overrun.
    - otherwise stay.
  - LOST: evt_valid=1; at least one event has been dropped.
    - ack & !edge -> IDLE.
    - ack & edge -> PENDING.
    - !ack & edge -> stay LOST.
    - otherwise stay.
- Overrun flag:
  - Set on any transition into LOST or any edge while in LOST.
  - Cleared by clr_overrun=1.
  - If set and clear occur in the same cycle, set wins.
  - clr_overrun does not change the FSM state.
- Unused state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package/header holds the FSM state encodings (IDLE=2'd0, PENDING=2'd1, LOST=2'd2) and the default SYNC_STAGES and CNT_W values.
- Natural sub-module: toggle_sync, a SYNC_STAGES-deep flop chain with clk and rst (synchronous, active-low) that outputs level. It is reusable for other toggle lines.

Test Plan (SYNC_STAGES=2, CNT_W=8):
1. Hold rst=0 for 3 cycles with toggle_in=1, then release -> level=0, pulse=0, evt_valid=0, evt_count=0, overrun=0 while held. The first edge after release is detected as an event.
2. Set toggle_in 0->1 before edge k, with evt_ack tied to 1 -> pulse high only in the cycle after edge k+2, evt_count=1, evt_valid high for 1 cycle. Then 1->0 -> a second pulse, evt_count=2.
3. Apply 3 toggles 4 cycles apart with evt_ack=0 -> evt_valid=1 throughout, FSM PENDING->LOST, overrun=1, evt_count=3. Then one ack -> evt_valid=0, overrun still 1. Then clr_overrun -> overrun=0.
4. In PENDING, pulse evt_ack in the same cycle an edge is detected -> evt_valid stays 1, overrun stays 0. A following lone ack -> evt_valid=0.
5. Apply 257 toggles at a 4-cycle spacing -> evt_count reads 255 after toggle 255, 0 after toggle 256 and 1 after toggle 257. No spurious pulses.
6. Assert rst=0 one cycle after toggle_in changes (in flight) with evt_valid=1 -> all outputs return to reset values and no pulse emerges. A later toggle is detected normally.
